// File: rtl/dmi_lock_gate.sv
// dmi_lock_gate
//   Core-clock gate between the JTAG DTM CDC and the debug module's DMI port.
//   It enforces the password lock: while locked, only dmstatus reads reach the
//   debug module, and every other access gets a local error response. Each
//   debug-module transaction is bounded by a timeout, so a hung DM cannot
//   wedge the DTM. At most one transaction is outstanding at a time.
//
// Ports
//   clk_i, rst_ni           clock, synchronous active-low reset
//   jtag_unlock_i           unlock level from the DTM (asynchronous)
//   up_req_*                request channel from the DTM  {addr[6:0], op[1:0], data[31:0]}
//   up_resp_*               response channel to the DTM   {data[31:0], resp[1:0]}
//   dm_req_*                request channel to the debug module
//   dm_resp_*               response channel from the debug module
//   unlocked_o              synchronized unlock status
//   reject_cnt_o            saturating count of locally rejected accesses
//   timeout_o               one-cycle pulse on each transaction timeout
module dmi_lock_gate #(
   parameter logic [6:0] StatusAddr    = 7'h11,
   parameter int         TimeoutCycles = 1024,
   parameter int         RejCntWidth   = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   jtag_unlock_i,
   input  logic [40:0]            up_req_i,
   input  logic                   up_req_valid_i,
   output logic                   up_req_ready_o,
   output logic [33:0]            up_resp_o,
   output logic                   up_resp_valid_o,
   input  logic                   up_resp_ready_i,
   output logic [40:0]            dm_req_o,
   output logic                   dm_req_valid_o,
   input  logic                   dm_req_ready_i,
   input  logic [33:0]            dm_resp_i,
   input  logic                   dm_resp_valid_i,
   output logic                   dm_resp_ready_o,
   output logic                   unlocked_o,
   output logic [RejCntWidth-1:0] reject_cnt_o,
   output logic                   timeout_o
);

   localparam int TW = $clog2(TimeoutCycles + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

   // The local-response step is folded into the acceptance edge: the
   // response register is loaded as the request is accepted, so a local
   // reply is visible on the very next cycle.
   typedef enum logic [2:0] {
      S_IDLE, S_FWD, S_WAIT, S_RESP, S_DRAIN
   } state_t;

   state_t                 r_state, w_next;
   logic                   r_sync1, r_sync2;
   logic [40:0]            r_req;
   logic [33:0]            r_resp;
   logic                   r_drain;
   logic [TW-1:0]          r_timer;
   logic [RejCntWidth-1:0] r_rej;

   logic [1:0] w_op;
   logic [6:0] w_addr;
   logic       w_nop, w_fwd, w_rej, w_accept, w_tmo_hit, w_timeout;

   // Classification of the incoming request; the lock state is sampled only
   // here, so unlock changes never affect an in-flight transaction.
   assign w_addr    = up_req_i[40:34];
   assign w_op      = up_req_i[33:32];
   assign w_nop     = (w_op == 2'd0) || (w_op == 2'd3);
   assign w_fwd     = !w_nop && (r_sync2 || (w_op == 2'd1 && w_addr == StatusAddr));
   assign w_rej     = !w_nop && !w_fwd;
   assign w_accept  = up_req_valid_i && (r_state == S_IDLE);
   assign w_tmo_hit = (r_timer == TMO_LAST);
   // A response arriving in the terminal cycle wins over the timeout.
   assign w_timeout = (r_state == S_WAIT) && w_tmo_hit && !dm_resp_valid_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (up_req_valid_i) w_next = w_fwd ? S_FWD : S_RESP;
         S_FWD:   if (dm_req_ready_i) w_next = S_WAIT;
         S_WAIT:  if (dm_resp_valid_i || w_tmo_hit) w_next = S_RESP;
         S_RESP:  if (up_resp_ready_i) w_next = r_drain ? S_DRAIN : S_IDLE;
         S_DRAIN: if (dm_resp_valid_i || w_tmo_hit) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      up_req_ready_o  = (r_state == S_IDLE);
      dm_req_valid_o  = (r_state == S_FWD);
      dm_resp_ready_o = (r_state == S_WAIT) || (r_state == S_DRAIN);
      up_resp_valid_o = (r_state == S_RESP);
      timeout_o       = w_timeout;
      up_resp_o       = r_resp;
      dm_req_o        = r_req;
      unlocked_o      = r_sync2;
      reject_cnt_o    = r_rej;
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_req   <= '0;
         r_resp  <= '0;
         r_drain <= 1'b0;
         r_timer <= '0;
         r_rej   <= '0;
      end else begin
         r_sync1 <= jtag_unlock_i;
         r_sync2 <= r_sync1;

         if (w_accept) begin
            r_req <= up_req_i;
            if (!w_fwd) r_resp <= w_rej ? {32'h0, 2'd2} : 34'h0;
            if (w_rej && r_rej != '1) r_rej <= r_rej + RejCntWidth'(1);
         end

         if (r_state == S_WAIT) begin
            if (dm_resp_valid_i) begin
               r_resp <= dm_resp_i;
            end else if (w_tmo_hit) begin
               r_resp  <= {32'h0, 2'd3};
               r_drain <= 1'b1;
            end
         end

         if (r_state == S_RESP && up_resp_ready_i) r_drain <= 1'b0;

         // Timer runs only while waiting on the DM (WaitResp, Drain); it is
         // zero on entry to either and holds at its terminal value.
         if (r_state == S_WAIT || r_state == S_DRAIN) begin
            if (r_timer != TW'(TimeoutCycles)) r_timer <= r_timer + TW'(1);
         end else begin
            r_timer <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmi_lock_gate.sv
module tb_dmi_lock_gate;

   localparam int T = 1024;

   logic        clk_i = 0;
   logic        rst_ni;
   logic        jtag_unlock_i;
   logic [40:0] up_req_i;
   logic        up_req_valid_i;
   logic        up_req_ready_o;
   logic [33:0] up_resp_o;
   logic        up_resp_valid_o;
   logic        up_resp_ready_i;
   logic [40:0] dm_req_o;
   logic        dm_req_valid_o;
   logic        dm_req_ready_i;
   logic [33:0] dm_resp_i;
   logic        dm_resp_valid_i;
   logic        dm_resp_ready_o;
   logic        unlocked_o;
   logic [7:0]  reject_cnt_o;
   logic        timeout_o;

   dmi_lock_gate dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .jtag_unlock_i(jtag_unlock_i),
      .up_req_i(up_req_i), .up_req_valid_i(up_req_valid_i), .up_req_ready_o(up_req_ready_o),
      .up_resp_o(up_resp_o), .up_resp_valid_o(up_resp_valid_o), .up_resp_ready_i(up_resp_ready_i),
      .dm_req_o(dm_req_o), .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i),
      .dm_resp_i(dm_resp_i), .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o),
      .unlocked_o(unlocked_o), .reject_cnt_o(reject_cnt_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_chk = 0, n_err = 0;
   int          cyc = 0, n_tmo = 0, tmo_cyc = 0, n_fwd = 0;
   logic [33:0] sb_q[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Scoreboard: compare every upstream response handshake against the queue.
   always @(negedge clk_i) begin
      if (rst_ni && up_resp_valid_o && up_resp_ready_i) begin
         if (sb_q.size() == 0) chk("unexp_resp", {63'h0, up_resp_valid_o}, 64'h0);
         else                  chk("resp", {30'h0, up_resp_o}, {30'h0, sb_q.pop_front()});
      end
      if (timeout_o) begin
         n_tmo++;
         tmo_cyc = cyc;
      end
      if (dm_req_valid_o) n_fwd++;
   end

   task automatic tick();
      @(posedge clk_i); #1;
   endtask

   // Drive a request and return one cycle after acceptance (cycle N+1).
   task automatic send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
      bit ok = 0;
      up_req_i = {a, op, d};
      up_req_valid_i = 1;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk_i);
         if (up_req_ready_o) ok = 1;
      end
      if (!ok) chk("req_accept_timeout", {63'h0, up_req_ready_o}, 64'h1);
      tick();
      up_req_valid_i = 0;
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
      chk("resp_pending", sb_q.size(), 0);
   endtask

   task automatic dm_accept();
      dm_req_ready_i = 1;
      tick();
      dm_req_ready_i = 0;
   endtask

   initial begin
      int c, f0;
      bit ok;
      rst_ni = 0; jtag_unlock_i = 0; up_req_i = '0; up_req_valid_i = 0;
      up_resp_ready_i = 1; dm_req_ready_i = 0; dm_resp_i = '0; dm_resp_valid_i = 0;
      repeat (3) tick();
      chk("rst_req_ready", up_req_ready_o, 1);
      chk("rst_resp_valid", up_resp_valid_o, 0);
      chk("rst_dm_valid", dm_req_valid_o, 0);
      chk("rst_unlocked", unlocked_o, 0);
      chk("rst_rejcnt", reject_cnt_o, 0);
      rst_ni = 1;
      tick();

      // Locked status read is forwarded unchanged.
      sb_q.push_back({32'h0003_0C82, 2'd0});
      send(7'h11, 2'd1, 32'h0);
      chk("stat_fwd_valid", dm_req_valid_o, 1);
      chk("stat_fwd_req", dm_req_o, {7'h11, 2'd1, 32'h0});
      dm_accept();
      dm_resp_i = {32'h0003_0C82, 2'd0}; dm_resp_valid_i = 1;
      tick();
      dm_resp_valid_i = 0;
      wait_resp();
      chk("stat_rejcnt", reject_cnt_o, 0);

      // Locked write: local error at N+1, counter saturates.
      f0 = n_fwd;
      for (int i = 0; i < 300; i++) begin
         sb_q.push_back({32'h0, 2'd2});
         send(7'h10, 2'd2, 32'h8000_0001);
         if (i == 0) begin
            chk("rej_n1_valid", up_resp_valid_o, 1);
            chk("rej_n1_data", up_resp_o, {32'h0, 2'd2});
         end
         wait_resp();
         if (i == 0) chk("rej_cnt1", reject_cnt_o, 1);
      end
      chk("rej_sat", reject_cnt_o, 8'hFF);
      chk("rej_no_fwd", n_fwd - f0, 0);

      // Unlock, forwarded write with DM ready delayed 5 cycles.
      jtag_unlock_i = 1;
      tick(); tick();
      chk("unlocked", unlocked_o, 1);
      sb_q.push_back({32'h1234_5678, 2'd0});
      send(7'h10, 2'd2, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         chk("wr_hold_valid", dm_req_valid_o, 1);
         chk("wr_hold_req", dm_req_o, {7'h10, 2'd2, 32'hDEAD_BEEF});
         tick();
      end
      dm_accept();
      tick();
      dm_resp_i = {32'h1234_5678, 2'd0}; dm_resp_valid_i = 1;
      tick();
      dm_resp_valid_i = 0;
      wait_resp();
      chk("wr_rejcnt", reject_cnt_o, 8'hFF);

      // DM never responds: timeout, busy response, late response drained.
      sb_q.push_back({32'h0, 2'd3});
      send(7'h04, 2'd1, 32'h0);
      c = cyc;
      dm_accept();
      for (int i = 0; i < T + 5 && n_tmo == 0; i++) tick();
      chk("tmo_count", n_tmo, 1);
      chk("tmo_cycle", tmo_cyc - c, T);
      wait_resp();
      while (cyc < tmo_cyc + 10) tick();
      chk("drain_req_ready", up_req_ready_o, 0);
      dm_resp_i = {32'h0000_0BAD, 2'd0}; dm_resp_valid_i = 1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_i);
         if (dm_resp_ready_o) ok = 1;
      end
      chk("drain_consume", ok, 1);
      tick();
      dm_resp_valid_i = 0;
      chk("drain_done_ready", up_req_ready_o, 1);

      // Response and timeout in the same cycle; upstream stalls 20 cycles.
      send(7'h05, 2'd1, 32'h0);
      dm_accept();
      up_resp_ready_i = 0;
      repeat (T - 1) tick();
      dm_resp_i = {32'hCAFE_F00D, 2'd0}; dm_resp_valid_i = 1;
      @(negedge clk_i);
      chk("race_no_tmo", timeout_o, 0);
      tick();
      dm_resp_valid_i = 0;
      for (int i = 0; i < 20; i++) begin
         chk("stall_valid", up_resp_valid_o, 1);
         chk("stall_data", up_resp_o, {32'hCAFE_F00D, 2'd0});
         chk("stall_req_ready", up_req_ready_o, 0);
         tick();
      end
      sb_q.push_back({32'hCAFE_F00D, 2'd0});
      up_resp_ready_i = 1;
      wait_resp();
      chk("race_tmo_total", n_tmo, 1);

      // Reset during WaitResp abandons the transaction.
      send(7'h06, 2'd1, 32'h0);
      dm_accept();
      repeat (3) tick();
      rst_ni = 0;
      tick();
      chk("mid_rst_resp_valid", up_resp_valid_o, 0);
      chk("mid_rst_dm_valid", dm_req_valid_o, 0);
      chk("mid_rst_dm_rready", dm_resp_ready_o, 0);
      chk("mid_rst_unlocked", unlocked_o, 0);
      chk("mid_rst_rejcnt", reject_cnt_o, 0);
      chk("mid_rst_resp", up_resp_o, 0);
      chk("mid_rst_dmreq", dm_req_o, 0);
      chk("mid_rst_tmo", timeout_o, 0);
      rst_ni = 1;
      repeat (5) tick();
      sb_q.push_back({32'h0, 2'd0});
      send(7'h00, 2'd0, 32'h0);
      wait_resp();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmi_lock_gate.md
Name: dmi_lock_gate

Overview:
- Sits on the core clock side, directly downstream of the JTAG DTM's CDC output and upstream of the debug module's DMI port.
- Enforces the JTAG password lock on every DMI transaction: while locked, only status reads pass and all other accesses get a local error response.
- Bounds every debug-module transaction with a timeout so a hung debug module cannot wedge the DTM.
- Allows one outstanding transaction at a time and uses registered valid/ready handshakes on all four channels.

Parameters:
- StatusAddr, 7'h11, DMI address (dmstatus) that stays readable while locked.
- TimeoutCycles, 1024, number of cycles to wait for a debug-module response before giving up; must be >= 2.
- RejCntWidth, 8, width of the saturating reject counter.

Ports:
- clk_i  in  1  core/DMI clock
- rst_ni  in  1  synchronous active-low reset
- jtag_unlock_i  in  1  unlock level from the DTM password check; asynchronous to clk_i
- up_req_i  in  41  dm::dmi_req_t {addr[6:0], op[1:0], data[31:0]} from the DTM CDC
- up_req_valid_i  in  1  upstream request valid
- up_req_ready_o  out  1  upstream request ready
- up_resp_o  out  34  dm::dmi_resp_t {data[31:0], resp[1:0]} to the DTM CDC
- up_resp_valid_o  out  1  upstream response valid
- up_resp_ready_i  in  1  upstream response ready
- dm_req_o  out  41  request to the debug module
- dm_req_valid_o  out  1  debug-module request valid
- dm_req_ready_i  in  1  debug-module request ready
- dm_resp_i  in  34  response from the debug module
- dm_resp_valid_i  in  1  debug-module response valid
- dm_resp_ready_o  out  1  debug-module response ready
- unlocked_o  out  1  synchronized unlock status
- reject_cnt_o  out  RejCntWidth  saturating count of locally rejected accesses
- timeout_o  out  1  one-cycle pulse on each transaction timeout

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - state = Idle; unlock synchronizer = 0 (locked); counters = 0.
  - All outputs 0, except up_req_ready_o, which goes to 1 once Idle is reached on the next cycle.
  - Reset mid-transaction abandons it; no response is issued.
- Unlock synchronization: jtag_unlock_i passes through a 2-flop synchronizer; unlocked_o is the second flop. The lock decision is taken only at request acceptance, so later unlock changes do not affect an in-flight transaction.
- up_req_ready_o = (state == Idle). A request is accepted when up_req_valid_i && up_req_ready_o in cycle N; the request is latched into a register.
- Classification at acceptance:
  - op 0 (NOP) or op 3 → LocalResp: data 0, resp 0.
  - Locked, op 1, addr == StatusAddr → Forward.
  - Locked, any other op 1/op 2 → LocalResp: data 0, resp 2 (op failed); reject_cnt increments and saturates at all-ones.
  - Unlocked, op 1 or op 2 → Forward.
- States:
  - Idle: waits for a request, then moves to Fwd or LocalResp.
  - Fwd: dm_req_valid_o = 1 and dm_req_o holds the latched request, stable until dm_req_ready_i. On handshake → WaitResp with the timeout counter cleared.
  - WaitResp: dm_resp_ready_o = 1 and the timer counts up. On dm_resp_valid_i, latch dm_resp_i into the response register → RespOut. If the timer reaches TimeoutCycles-1 with no response, timeout_o pulses and the response register is set to data 32'h0, resp 3 (busy) → RespOut with drain_pending set. A response and the timeout in the same cycle: the response wins and there is no timeout.
  - Fwd has no timeout; the request is held indefinitely (DMI protocol).
  - LocalResp: loads the response register → RespOut. First up_resp_valid_o is at N+1 for local responses.
  - RespOut: up_resp_valid_o = 1 with up_resp_o stable until up_resp_ready_i. Then go to Drain if drain_pending, else Idle.
  - Drain: dm_resp_ready_o = 1. A late response is consumed and discarded → Idle. Otherwise → Idle after TimeoutCycles cycles. up_req_ready_o = 0 throughout.
- dm_resp_ready_o = 0 outside WaitResp and Drain; a dm_resp_valid_i seen in any other state is ignored (not consumed).
- Forward latency: dm_req_valid_o is first high at N+1. Response latency is DM latency + 1 cycle (registered).
- The timer is $clog2(TimeoutCycles+1) bits and never wraps; it stops at the terminal value.

Test Plan:
- Locked, read addr 7'h11 → forwarded unchanged; DM returns data 32'h0003_0C82, resp 0 → up_resp_o = {32'h0003_0C82, 2'b0}; reject_cnt_o stays 0.
- Locked, write addr 7'h10 data 32'h8000_0001 → dm_req_valid_o never rises; up_resp_valid_o at N+1 with data 0, resp 2; reject_cnt_o = 1. Repeat 300 times → reject_cnt_o saturates at 8'hFF.
- Raise jtag_unlock_i, wait 2 cycles (unlocked_o = 1), then write addr 7'h10 → forwarded with dm_req_ready_i delayed 5 cycles; request stays stable; resp 0 is passed back.
- Unlocked read, DM never responds → timeout_o pulses at cycle TimeoutCycles after the DM handshake; response is resp 3, data 0. DM response arriving 10 cycles later is drained and discarded. The next request is accepted only after Drain ends.
- Response and timeout in the same cycle → DM data is returned and timeout_o stays low. Hold up_resp_ready_i low for 20 cycles → response stays stable and up_req_ready_o stays 0.
- Assert rst_ni low during WaitResp → next cycle all outputs 0, unlocked_o = 0, no response emitted; a new request is accepted after reset.
